serial_addsub: RTL

Parametrised, multi-cycle signed/unsigned add/subtract unit. It processes a WIDTH-bit operand pair DIGIT bits per clock, least-significant digit first, using one narrow ripple slice. It returns the sum or difference with carry/borrow, overflow, zero and negative flags over a valid/ready handshake. It sits between the operand register file and the result bus of the ALU, and is the area-scalable successor of the fixed 4-bit combinational add/sub.

---
 rtl/serial_addsub_pkg.sv | 17 +
 rtl/serial_addsub_digit_adder.sv | 28 ++
 rtl/serial_addsub.sv | 135 +++++++++++++
 3 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the digit-serial add/subtract unit.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// One DIGIT-wide ripple slice; also exposes the carry into its MSB for overflow detection.
module digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] cy;

  always_comb begin
    cy    = '0;
    sum   = '0;
    cy[0] = cin;
    for (int i = 0; i < int'(DIGIT); i++) begin
      sum[i]   = a[i] ^ b[i] ^ cy[i];
      cy[i+1]  = (a[i] & b[i]) | (a[i] & cy[i]) | (b[i] & cy[i]);
    end
  end

  assign cout = cy[DIGIT];
  assign cmsb = cy[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial signed/unsigned add/subtract with valid/ready handshake.
// Define SERIAL_ADDSUB_SAT_EN to add the sat port and signed saturation.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
`ifdef SERIAL_ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v,
  output logic             z,
  output logic             n
);

  localparam int unsigned NDIG = ndig(WIDTH, DIGIT);
  localparam int unsigned SW   = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST_POS = SW'((NDIG - 1) * DIGIT);

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             op_r;
  logic             cy;
  logic [SW-1:0]    pos;
`ifdef SERIAL_ADDSUB_SAT_EN
  logic             sat_r;
`endif

  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             dcmsb;
  logic             vraw;
  logic [WIDTH-1:0] s_nxt;
  logic [WIDTH-1:0] s_fin;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a    (a_r[pos +: DIGIT]),
    .b    (b_r[pos +: DIGIT]),
    .cin  (cy),
    .sum  (dsum),
    .cout (dcout),
    .cmsb (dcmsb)
  );

  assign vraw = dcmsb ^ dcout;

  // Merge the current digit into s; on the last digit this is the final result.
  always_comb begin
    s_nxt              = s;
    s_nxt[pos +: DIGIT] = dsum;
    s_fin              = s_nxt;
`ifdef SERIAL_ADDSUB_SAT_EN
    // On overflow the raw sign is inverted relative to the true result.
    if (sat_r && vraw) begin
      s_fin = s_nxt[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s         <= '0;
      c         <= 1'b0;
      v         <= 1'b0;
      z         <= 1'b0;
      n         <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= OP_ADD;
      cy        <= 1'b0;
      pos       <= '0;
`ifdef SERIAL_ADDSUB_SAT_EN
      sat_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b ^ {WIDTH{op}};
            op_r     <= op;
            cy       <= op;
            pos      <= '0;
`ifdef SERIAL_ADDSUB_SAT_EN
            sat_r    <= sat;
`endif
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          s   <= s_nxt;
          cy  <= dcout;
          pos <= pos + SW'(DIGIT);
          if (pos == LAST_POS) begin
            s         <= s_fin;
            c         <= dcout ^ op_r;
            v         <= vraw;
            z         <= (s_fin == '0);
            n         <= s_fin[WIDTH-1];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
